// File: rtl/regfile_mp_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared types, default sizes and port-slicing helper for regfile_mp.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

  // Clear-sequencer state; CLEAR doubles as the Busy indication.
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  localparam int WIDTH      = 32;
  localparam int ADDR_WIDTH = 5;

  // LSB position of field `idx` in a packed bus of `w`-bit fields.
  function automatic int unsigned port_lsb(input int unsigned idx, input int unsigned w);
    return idx * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_mp_read_port.sv
// ============================================================================
// Module : regfile_read_port
// Brief  : One combinational read port: zero-register and Busy masking, plus
//          same-cycle write bypass when REGFILE_MP_BYPASS_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int NW     = 1
) (
  input  logic [DATA_W-1:0]    i_raw,
  input  logic [NW-1:0]        i_we,
  input  logic [NW*ADDR_W-1:0] i_wa,
  input  logic [NW*DATA_W-1:0] i_wd,
  input  logic                 i_busy,
  input  logic [ADDR_W-1:0]    i_ra,
  output logic [DATA_W-1:0]    o_data
);

`ifdef REGFILE_MP_BYPASS_EN
  // Forward matching write data; ascending loop lets the highest port win.
  always_comb begin
    o_data = i_raw;
    for (int i = 0; i < NW; i++) begin
      if (i_we[i] && (i_wa[port_lsb(i, ADDR_W) +: ADDR_W] == i_ra) &&
          (32'(i_ra) < DEPTH)) begin
        o_data = i_wd[port_lsb(i, DATA_W) +: DATA_W];
      end
    end
    if (i_busy || (i_ra == '0)) begin
      o_data = '0;
    end
  end
`else
  // Write buses only matter to the bypass path.
  logic w_unused;
  assign w_unused = ^{i_we, i_wa, i_wd};

  // Array contents only, masked for register 0 and during the clear sweep.
  always_comb begin
    o_data = i_raw;
    if (i_busy || (i_ra == '0)) begin
      o_data = '0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ============================================================================
// Module : regfile_mp
// Brief  : Multi-port register file, NR combinational reads, NW synchronous
//          writes, register 0 hardwired to zero, sequenced clear after reset
//          or on request. Optional macro: REGFILE_MP_BYPASS_EN (same-cycle
//          write-to-read bypass).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_mp
  import regfile_pkg::*;
#(
  parameter int width     = WIDTH,
  parameter int addrWidth = ADDR_WIDTH,
  parameter int depth     = 2 ** addrWidth,
  parameter int NR        = 2,
  parameter int NW        = 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    Clear,
  output logic                    Busy,
  input  logic [NW-1:0]           WriteEnable,
  input  logic [NW*addrWidth-1:0] WriteRegister,
  input  logic [NW*width-1:0]     WriteData,
  input  logic [NR*addrWidth-1:0] ReadRegister,
  output logic [NR*width-1:0]     ReadData
);

  localparam logic [addrWidth-1:0] c_last = addrWidth'(depth - 1);
  localparam logic [addrWidth-1:0] c_first = addrWidth'(1);

  state_t               r_st;
  logic [addrWidth-1:0] r_ptr;
  logic [width-1:0]     r_regs [depth];

  logic [addrWidth-1:0] w_wa  [NW];
  logic [width-1:0]     w_wd  [NW];
  logic [addrWidth-1:0] w_ra  [NR];
  logic [width-1:0]     w_raw [NR];
  logic                 w_busy;

  assign w_busy = (r_st == ST_CLEAR);
  assign Busy   = w_busy;

  generate
    for (genvar i = 0; i < NW; i++) begin : g_wr_unpack
      assign w_wa[i] = WriteRegister[port_lsb(i, addrWidth) +: addrWidth];
      assign w_wd[i] = WriteData[port_lsb(i, width) +: width];
    end
  endgenerate

  // Clear sequencer: sweeps ptr from 1 to depth-1, restarted by Reset or Clear.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_st  <= ST_CLEAR;
      r_ptr <= c_first;
    end else if (Clear) begin
      r_st  <= ST_CLEAR;
      r_ptr <= c_first;
    end else if (r_st == ST_CLEAR) begin
      r_ptr <= r_ptr + 1'b1;
      if (r_ptr == c_last) begin
        r_st <= ST_IDLE;
      end
    end
  end

  // Storage update: sweep zeroing while busy, otherwise port writes in
  // ascending order so the highest port wins on an address collision.
  always_ff @(posedge Clk) begin
    if (r_st == ST_CLEAR) begin
      if (32'(r_ptr) < depth) begin
        r_regs[r_ptr] <= '0;
      end
    end else if (!Clear) begin
      for (int i = 0; i < NW; i++) begin
        if (WriteEnable[i] && (w_wa[i] != '0) && (32'(w_wa[i]) < depth)) begin
          r_regs[w_wa[i]] <= w_wd[i];
        end
      end
    end
  end

  generate
    for (genvar j = 0; j < NR; j++) begin : g_rd
      assign w_ra[j]  = ReadRegister[port_lsb(j, addrWidth) +: addrWidth];
      // Out-of-range addresses read as zero rather than indexing past the array.
      assign w_raw[j] = (32'(w_ra[j]) < depth) ? r_regs[w_ra[j]] : '0;

      regfile_read_port #(
        .DATA_W (width),
        .ADDR_W (addrWidth),
        .DEPTH  (depth),
        .NW     (NW)
      ) u_rd (
        .i_raw  (w_raw[j]),
        .i_we   (WriteEnable),
        .i_wa   (WriteRegister),
        .i_wd   (WriteData),
        .i_busy (w_busy),
        .i_ra   (w_ra[j]),
        .o_data (ReadData[port_lsb(j, width) +: width])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ============================================================================
// Module : tb_regfile_mp
// Brief  : Self-checking bench for regfile_mp: directed scenarios plus a
//          randomized phase against an array-based reference model. A second
//          instance with depth=24 covers non-power-of-2 depth.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_mp;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Clear;
  logic        Busy;
  logic [1:0]  WE;
  logic [9:0]  WR;
  logic [63:0] WD;
  logic [9:0]  RR;
  logic [63:0] RD;

  logic        Clear2;
  logic        Busy2;
  logic [0:0]  WE2;
  logic [4:0]  WR2;
  logic [31:0] WD2;
  logic [4:0]  RR2;
  logic [31:0] RD2;

  logic [31:0] mem [32];
  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  regfile_mp #(.width(32), .addrWidth(5), .depth(32), .NR(2), .NW(2)) dut (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .Busy(Busy),
    .WriteEnable(WE), .WriteRegister(WR), .WriteData(WD),
    .ReadRegister(RR), .ReadData(RD)
  );

  regfile_mp #(.width(32), .addrWidth(5), .depth(24), .NR(1), .NW(1)) dut24 (
    .Clk(Clk), .Reset(Reset), .Clear(Clear2), .Busy(Busy2),
    .WriteEnable(WE2), .WriteRegister(WR2), .WriteData(WD2),
    .ReadRegister(RR2), .ReadData(RD2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected read of address a in the current cycle (IDLE assumed).
  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : mem[a];
`ifdef REGFILE_MP_BYPASS_EN
    for (int i = 0; i < 2; i++) begin
      if (WE[i] && (WR[i*5 +: 5] == a) && (a != 5'd0)) v = WD[i*32 +: 32];
    end
`endif
    return v;
  endfunction

  // Check outputs for the driven inputs, clock once, update the model.
  task automatic step(input string tag);
    #1;
    chk({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    chk({tag, "_rd0"}, RD[31:0], exp_rd(RR[4:0]));
    chk({tag, "_rd1"}, RD[63:32], exp_rd(RR[9:5]));
    @(posedge Clk);
    for (int i = 0; i < 2; i++) begin
      if (WE[i] && (WR[i*5 +: 5] != 5'd0)) mem[WR[i*5 +: 5]] = WD[i*32 +: 32];
    end
    @(negedge Clk);
  endtask

  // Count rising edges until each instance drops Busy; bounded.
  task automatic count_sweep(output int n, output int n2);
    n = 0;
    n2 = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge Clk);
      #1;
      if ((n == 0) && !Busy) n = k;
      if ((n2 == 0) && !Busy2) n2 = k;
      if ((n != 0) && (n2 != 0)) break;
    end
    foreach (mem[i]) mem[i] = 32'd0;
  endtask

  initial begin
    int n, n2;
    logic [31:0] v;

    Reset = 1'b1; Clear = 1'b0; WE = '0; WR = '0; WD = '0; RR = '0;
    Clear2 = 1'b0; WE2 = '0; WR2 = '0; WD2 = '0; RR2 = '0;
    foreach (mem[i]) mem[i] = 32'd0;

    // Reset state
    repeat (3) @(negedge Clk);
    RR = {5'd3, 5'd1};
    #1;
    chk("reset_busy", {31'd0, Busy}, 32'd1);
    chk("reset_busy24", {31'd0, Busy2}, 32'd1);
    chk("reset_rd0", RD[31:0], 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    chk("release_busy", {31'd0, Busy}, 32'd1);
    count_sweep(n, n2);
    chk("sweep_edges", n, 32'd31);
    chk("sweep_edges24", n2, 32'd23);
    @(negedge Clk);
    for (int a = 0; a < 32; a++) begin
      RR = {5'(a), 5'(a)};
      #1;
      chk("post_reset_zero", RD[31:0], 32'd0);
    end

    // Basic write then read, register 0 hardwired
    WE = 2'b01; WR = {5'd0, 5'd5}; WD = {32'd0, 32'hDEADBEEF}; RR = {5'd0, 5'd5};
    step("wr5");
    WE = 2'b00; RR = {5'd0, 5'd5};
    #1;
    chk("rd5_direct", RD[31:0], 32'hDEADBEEF);
    chk("rd0_direct", RD[63:32], 32'd0);
    step("rd5");
    WE = 2'b01; WR = {5'd0, 5'd0}; WD = {32'd0, 32'hFFFFFFFF}; RR = {5'd0, 5'd0};
    step("wr0");
    WE = 2'b00;
    #1;
    chk("rd0_after_wr0", RD[31:0], 32'd0);
    step("rd0");

    // Same-cycle write/read of reg 9
    WE = 2'b01; WR = {5'd0, 5'd9}; WD = {32'd0, 32'h0000CAFE}; RR = {5'd0, 5'd9};
    #1;
`ifdef REGFILE_MP_BYPASS_EN
    chk("bypass_same_cycle", RD[31:0], 32'h0000CAFE);
`else
    chk("nobypass_same_cycle", RD[31:0], 32'd0);
`endif
    step("wr9");
    WE = 2'b00;
    #1;
    chk("rd9_next", RD[31:0], 32'h0000CAFE);

    // Two ports, same address: highest port wins
    WE = 2'b11; WR = {5'd7, 5'd7}; WD = {32'h22, 32'h11}; RR = {5'd7, 5'd7};
    step("dual_wr7");
    WE = 2'b00;
    #1;
    chk("rd7_port1_wins", RD[31:0], 32'h22);

    // Clear with a concurrent write: write dropped, sweep of 31 edges
    Clear = 1'b1; WE = 2'b01; WR = {5'd0, 5'd3}; WD = {32'd0, 32'h55}; RR = {5'd7, 5'd3};
    @(posedge Clk);
    #1;
    Clear = 1'b0; WE = 2'b00;
    chk("clear_busy", {31'd0, Busy}, 32'd1);
    chk("busy_rd_mask", RD[63:32], 32'd0);
    count_sweep(n, n2);
    chk("clear_sweep_edges", n, 32'd31);
    @(negedge Clk);
    chk("rd3_after_clear", RD[31:0], 32'd0);
    chk("rd7_after_clear", RD[63:32], 32'd0);

    // Reset mid-sweep at ptr=10, writes during Busy are ignored
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1; WE = 2'b11; WR = {5'd4, 5'd4}; WD = {$urandom, $urandom}; RR = {5'd4, 5'd4};
    @(negedge Clk);
    Reset = 1'b0;
    count_sweep(n, n2);
    WE = 2'b00;
    chk("midsweep_edges", n, 32'd31);
    chk("midsweep_edges24", n2, 32'd23);
    @(negedge Clk);
    chk("rd4_after_busy_writes", RD[31:0], 32'd0);

    // depth=24 instance: out-of-range write ignored, in-range write kept
    WE2 = 1'b1; WR2 = 5'd30; WD2 = 32'h1234; RR2 = 5'd30;
    @(negedge Clk);
    WR2 = 5'd20; WD2 = 32'hABCD;
    @(negedge Clk);
    WE2 = 1'b0;
    #1;
    chk("d24_rd30", RD2, 32'd0);
    RR2 = 5'd20;
    #1;
    chk("d24_rd20", RD2, 32'hABCD);

    // Randomized traffic against the model
    for (int c = 0; c < 300; c++) begin
      WE = 2'($urandom);
      WR = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
      WD = {$urandom, $urandom};
      RR = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
      step("rand");
    end
    WE = 2'b00;
    for (int a = 1; a < 10; a++) begin
      RR = {5'(a), 5'(a)};
      v = mem[a];
      #1;
      chk("final_sweep", RD[31:0], v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
